// File: rtl/dot_product_sequencer.sv
// dot_product_sequencer: sequential 8-element unsigned dot product over a shared operand memory
// Ports: clk, rst_n (async active-low), comp_start in; mem_addr/mem_rd out, mem_rdata in
//   (1-cycle synchronous read); busy, comp_done, comp_result, overflow out.
// Build option: DOTP_SATURATE_EN clamps comp_result to all-ones on overflow instead of truncating.
module dot_product_sequencer #(
    parameter int N_ELEM = 8,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int B_BASE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              comp_start,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              comp_done,
    output logic [DATA_W-1:0] comp_result,
    output logic              overflow
);
    localparam int ACC_W = 2*DATA_W + 3;
    localparam int IDX_W = $clog2(N_ELEM);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH_A = 3'd1;
    localparam logic [2:0] FETCH_B = 3'd2;
    localparam logic [2:0] MAC     = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
    logic [2:0]          state;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   a_reg;
    logic [ACC_W-1:0]    acc;
    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    acc_nxt;
    logic                ovf_nxt;
    logic [DATA_W-1:0]   res_nxt;
    logic                last;
    // In MAC the read data returning is the B element; a_reg holds the A element.
    assign prod    = {{DATA_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, mem_rdata};
    assign acc_nxt = acc + {3'b000, prod};
    assign ovf_nxt = |acc_nxt[ACC_W-1:DATA_W];
`ifdef DOTP_SATURATE_EN
    assign res_nxt = ovf_nxt ? {DATA_W{1'b1}} : acc_nxt[DATA_W-1:0];
`else
    assign res_nxt = acc_nxt[DATA_W-1:0];
`endif
    assign last      = idx == IDX_W'(N_ELEM - 1);
    assign mem_rd    = state == FETCH_A || state == FETCH_B;
    assign mem_addr  = state == FETCH_A ? ADDR_W'(idx) :
                       state == FETCH_B ? ADDR_W'(B_BASE) + ADDR_W'(idx) : '0;
    assign busy      = state != IDLE;
    assign comp_done = state == DONE;
    // DONE also samples comp_start so a held start restarts with no idle bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            a_reg       <= '0;
            acc         <= '0;
            comp_result <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    state <= comp_start ? FETCH_A : IDLE;
                    if (comp_start) begin
                        acc <= '0;
                        idx <= '0;
                    end
                end
                FETCH_A: state <= FETCH_B;
                FETCH_B: begin
                    a_reg <= mem_rdata;
                    state <= MAC;
                end
                MAC: begin
                    acc   <= acc_nxt;
                    state <= last ? DONE : FETCH_A;
                    if (last) begin
                        comp_result <= res_nxt;
                        overflow    <= ovf_nxt;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dot_product_sequencer.sv
// tb_dot_product_sequencer: directed vector bench for dot_product_sequencer
module tb_dot_product_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       comp_start = 1'b0;
    logic [3:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata;
    logic       busy;
    logic       comp_done;
    logic [7:0] comp_result;
    logic       overflow;
    logic [7:0] mem [16];

    typedef struct {
        logic [7:0][7:0] a;
        logic [7:0][7:0] b;
        int              res_sat;
        int              res_trunc;
        int              ovf;
    } vec_t;

    vec_t vecs[6];
    int   n_chk = 0;
    int   n_fail = 0;

    dot_product_sequencer dut (
        .clk(clk), .rst_n(rst_n), .comp_start(comp_start),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .busy(busy), .comp_done(comp_done), .comp_result(comp_result),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_res(input vec_t v);
`ifdef DOTP_SATURATE_EN
        return v.res_sat;
`else
        return v.res_trunc;
`endif
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            mem[i]     = v.a[i];
            mem[8 + i] = v.b[i];
        end
    endtask

    // Start one run; cycle c is the c-th cycle after the start edge E0.
    // Extra comp_start pulses are injected at cycles p1/p2 (0 = none).
    task automatic run(input vec_t v, input string name, input int p1, input int p2);
        bit   trace_ok;
        bit   early;
        int   ph;
        int   e;
        int   ea;
        logic erd;
        trace_ok = 1'b1;
        early    = 1'b0;
        @(negedge clk);
        load(v);
        comp_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        comp_start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            ph  = (c - 1) % 3;
            e   = (c - 1) / 3;
            erd = (c <= 24) && (ph < 2);
            ea  = !erd ? 0 : (ph == 0 ? e : 8 + e);
            if (mem_rd !== erd || mem_addr !== 4'(ea) || busy !== 1'b1) trace_ok = 1'b0;
            if (c < 25 && comp_done) early = 1'b1;
            if (c < 25) begin
                @(negedge clk);
                comp_start = (c + 1 == p1) || (c + 1 == p2);
            end
        end
        chk({name, " addr/rd/busy trace"}, int'(trace_ok), 1);
        chk({name, " done at E0+24"}, early ? 0 : int'(comp_done), 1);
        chk({name, " result"}, int'(comp_result), exp_res(v));
        chk({name, " overflow"}, int'(overflow), v.ovf);
        @(negedge clk);
        chk({name, " busy/done low after"}, int'({busy, comp_done}), 0);
    endtask

    initial begin
        int d1;
        int d2;
        int extra;
        for (int i = 0; i < 8; i++) begin
            vecs[0].a[i] = 8'(i + 1);  vecs[0].b[i] = 8'(i + 10);
            vecs[1].a[i] = 8'd1;       vecs[1].b[i] = 8'd2;
            vecs[2].a[i] = 8'd255;     vecs[2].b[i] = 8'd255;
            vecs[3].a[i] = 8'd0;       vecs[3].b[i] = 8'd0;
            vecs[4].a[i] = 8'd1;       vecs[4].b[i] = (i == 7) ? 8'd31 : 8'd32;
            vecs[5].a[i] = 8'd1;       vecs[5].b[i] = 8'd32;
        end
        vecs[0].res_sat = 255; vecs[0].res_trunc = 16;  vecs[0].ovf = 1;
        vecs[1].res_sat = 16;  vecs[1].res_trunc = 16;  vecs[1].ovf = 0;
        vecs[2].res_sat = 255; vecs[2].res_trunc = 8;   vecs[2].ovf = 1;
        vecs[3].res_sat = 0;   vecs[3].res_trunc = 0;   vecs[3].ovf = 0;
        vecs[4].res_sat = 255; vecs[4].res_trunc = 255; vecs[4].ovf = 0;
        vecs[5].res_sat = 255; vecs[5].res_trunc = 0;   vecs[5].ovf = 1;

        #3;
        chk("reset busy", int'(busy), 0);
        chk("reset comp_done", int'(comp_done), 0);
        chk("reset comp_result", int'(comp_result), 0);
        chk("reset overflow", int'(overflow), 0);
        chk("reset mem_rd", int'(mem_rd), 0);
        chk("reset mem_addr", int'(mem_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 6; k++) run(vecs[k], $sformatf("vec%0d", k), 0, 0);

        // Starts while busy are ignored: one done, unchanged result.
        run(vecs[0], "ignored starts", 5, 20);
        extra = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (comp_done) extra++;
        end
        chk("no queued run after ignored starts", extra, 0);
        run(vecs[3], "zeros after ignored", 0, 0);

        // Asynchronous abort mid-run.
        run(vecs[1], "pre-reset", 0, 0);
        @(negedge clk);
        load(vecs[0]);
        comp_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        comp_start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort comp_done", int'(comp_done), 0);
        chk("abort comp_result", int'(comp_result), 0);
        chk("abort overflow", int'(overflow), 0);
        chk("abort mem_rd", int'(mem_rd), 0);
        chk("abort mem_addr", int'(mem_addr), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (comp_done || busy) extra++;
        end
        chk("no done after abort", extra, 0);
        run(vecs[2], "after abort", 0, 0);

        // comp_start held high: back-to-back runs.
        @(negedge clk);
        load(vecs[1]);
        comp_start = 1'b1;
        d1 = -1;
        d2 = -1;
        for (int t = 1; t <= 80; t++) begin
            @(negedge clk);
            if (comp_done) begin
                if (d1 < 0) d1 = t;
                else if (d2 < 0) d2 = t;
            end
        end
        comp_start = 1'b0;
        chk("held start first done", d1, 25);
        chk("held start done spacing", d2 - d1, 25);
        chk("held start result", int'(comp_result), 16);
        extra = 0;
        for (int t = 0; t < 60 && busy; t++) @(negedge clk);
        chk("held start drains to idle", int'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
